binary_dispatcher: RTL and testbench

BINARY_DISPATCHER -- requirements
Module: binary_dispatcher

---
 rtl/binary_dispatch_pkg.sv | 16 +
 rtl/dispatch_slot.sv | 56 +++++
 rtl/binary_dispatcher.sv | 86 ++++++++
 tb/tb_binary_dispatcher.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_dispatch_pkg.sv
// Shared constants for the binary dispatcher: parameter defaults, the
// broadcast key pattern and the drop-counter ceiling.
package binary_dispatch_pkg;

  localparam int CANDIDATE_CNT_DEFAULT = 5;
  localparam int KEY_WIDTH_DEFAULT     = 6;
  localparam int DATA_WIDTH_DEFAULT    = 16;

  // Wide all-ones pattern; users slice off KEY_WIDTH bits to get their broadcast key.
  localparam int                        KEY_WIDTH_MAX = 32;
  localparam logic [KEY_WIDTH_MAX-1:0]  BCAST_KEY_ALL = '1;

  localparam int          DROP_CNT_WIDTH = 16;
  localparam logic [15:0] DROP_CNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/dispatch_slot.sv
// One-entry output slot for a single dispatch target; outputs come straight
// from the slot registers.
module dispatch_slot
  import binary_dispatch_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [KEY_WIDTH-1:0]  load_key,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_rdy,
  output logic                  out_vld,
  output logic [KEY_WIDTH-1:0]  out_key,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  slot_free
);

  logic                  vld_d, vld_q;
  logic [KEY_WIDTH-1:0]  key_d, key_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  // A drain and a refill at the same edge leave the slot full with the new item.
  always_comb begin
    vld_d  = vld_q;
    key_d  = key_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      key_d  = load_key;
      data_d = load_data;
    end else if (out_rdy) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      key_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      key_q  <= key_d;
      data_q <= data_d;
    end
  end

  assign slot_free = !vld_q || out_rdy;
  assign out_vld   = vld_q;
  assign out_key   = key_q;
  assign out_data  = data_q;

endmodule

// File: rtl/binary_dispatcher.sv
// Routes keyed items to one of CANDIDATE_CNT one-entry target slots, broadcasts
// the all-ones key to every slot, and drops and counts items with unused keys.
module binary_dispatcher
  import binary_dispatch_pkg::*;
#(
  parameter int CANDIDATE_CNT = CANDIDATE_CNT_DEFAULT,
  parameter int KEY_WIDTH     = KEY_WIDTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_vld,
  output logic                                in_rdy,
  input  logic [KEY_WIDTH-1:0]                in_key,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic [CANDIDATE_CNT-1:0]            out_vld,
  input  logic [CANDIDATE_CNT-1:0]            out_rdy,
  output logic [CANDIDATE_CNT*KEY_WIDTH-1:0]  out_key,
  output logic [CANDIDATE_CNT*DATA_WIDTH-1:0] out_data,
  output logic                                drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0]           drop_cnt
);

  localparam logic [KEY_WIDTH-1:0] BCAST_KEY = BCAST_KEY_ALL[KEY_WIDTH-1:0];
  localparam logic [KEY_WIDTH-1:0] CNT_KEY   = KEY_WIDTH'(CANDIDATE_CNT);

  logic [CANDIDATE_CNT-1:0]  slot_free;
  logic [CANDIDATE_CNT-1:0]  slot_load;
  logic                      is_bcast, is_unicast, is_illegal, sel_free, accept;
  logic                      drop_pulse_d, drop_pulse_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_d, drop_cnt_q;

  // in_rdy deliberately ignores in_vld so upstream may wait on it safely.
  always_comb begin
    is_bcast   = (in_key == BCAST_KEY);
    is_unicast = (in_key < CNT_KEY);
    is_illegal = !is_bcast && !is_unicast;
    sel_free   = 1'b0;
    for (int i = 0; i < CANDIDATE_CNT; i++) begin
      if (in_key == KEY_WIDTH'(i)) sel_free = slot_free[i];
    end
    if (is_unicast)    in_rdy = sel_free;
    else if (is_bcast) in_rdy = &slot_free;
    else               in_rdy = 1'b1;
    accept    = in_vld && in_rdy;
    slot_load = '0;
    for (int i = 0; i < CANDIDATE_CNT; i++) begin
      slot_load[i] = accept && (is_bcast || (in_key == KEY_WIDTH'(i)));
    end
    drop_pulse_d = accept && is_illegal;
    drop_cnt_d   = drop_cnt_q;
    if (drop_pulse_d && (drop_cnt_q != DROP_CNT_MAX)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

  for (genvar g = 0; g < CANDIDATE_CNT; g++) begin : g_slot
    dispatch_slot #(
      .KEY_WIDTH (KEY_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (slot_load[g]),
      .load_key (in_key),
      .load_data(in_data),
      .out_rdy  (out_rdy[g]),
      .out_vld  (out_vld[g]),
      .out_key  (out_key[g*KEY_WIDTH +: KEY_WIDTH]),
      .out_data (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .slot_free(slot_free[g])
    );
  end

endmodule

// File: tb/tb_binary_dispatcher.sv
// Scenario bench for binary_dispatcher with a per-target scoreboard and a
// reference model of in_rdy and the drop counter.
module tb_binary_dispatcher;

  localparam int CC = 5;
  localparam int KW = 6;
  localparam int DW = 16;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_vld = 1'b0;
  logic              in_rdy;
  logic [KW-1:0]     in_key = '0;
  logic [DW-1:0]     in_data = '0;
  logic [CC-1:0]     out_vld;
  logic [CC-1:0]     out_rdy = '1;
  logic [CC*KW-1:0]  out_key;
  logic [CC*DW-1:0]  out_data;
  logic              drop_pulse;
  logic [15:0]       drop_cnt;

  int compared = 0;
  int mismatched = 0;

  item_t       sbq [CC][$];
  logic [15:0] exp_drop = '0;
  logic        exp_pulse = 1'b0;
  logic [CC-1:0] mon_free;
  logic        mon_rdy;
  item_t       mon_item;

  always #5 clk = ~clk;

  binary_dispatcher #(.CANDIDATE_CNT(CC), .KEY_WIDTH(KW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_key(in_key),
    .in_data(in_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_key(out_key),
    .out_data(out_data), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  function automatic logic [KW-1:0] key_of(int i);
    return out_key[i*KW +: KW];
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    return out_data[i*DW +: DW];
  endfunction

  // Scoreboard: push on acceptance, compare/pop while the item sits in its slot.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CC; i++) sbq[i].delete();
      exp_drop  = '0;
      exp_pulse = 1'b0;
    end else begin
      for (int i = 0; i < CC; i++) mon_free[i] = (sbq[i].size() == 0) || out_rdy[i];
      if (in_key == 6'h3F)   mon_rdy = &mon_free;
      else if (in_key < CC)  mon_rdy = mon_free[in_key];
      else                   mon_rdy = 1'b1;
      compared++;
      if (in_rdy !== mon_rdy) begin
        mismatched++;
        $display("FAIL sb_in_rdy key=%0d: got %b want %b", in_key, in_rdy, mon_rdy);
      end
      compared++;
      if (drop_cnt !== exp_drop) begin
        mismatched++;
        $display("FAIL sb_drop_cnt: got %h want %h", drop_cnt, exp_drop);
      end
      compared++;
      if (drop_pulse !== exp_pulse) begin
        mismatched++;
        $display("FAIL sb_drop_pulse: got %b want %b", drop_pulse, exp_pulse);
      end
      for (int i = 0; i < CC; i++) begin
        compared++;
        if (out_vld[i] !== (sbq[i].size() != 0)) begin
          mismatched++;
          $display("FAIL sb_out_vld[%0d]: got %b want %b", i, out_vld[i], sbq[i].size() != 0);
        end
        if (sbq[i].size() != 0) begin
          mon_item = sbq[i][0];
          compared++;
          if ({key_of(i), data_of(i)} !== mon_item) begin
            mismatched++;
            $display("FAIL sb_item[%0d]: got key %h data %h want key %h data %h",
                     i, key_of(i), data_of(i), mon_item.k, mon_item.d);
          end
          if (out_rdy[i]) void'(sbq[i].pop_front());
        end
      end
      exp_pulse = 1'b0;
      if (in_vld && mon_rdy) begin
        if (in_key == 6'h3F) begin
          for (int i = 0; i < CC; i++) sbq[i].push_back({in_key, in_data});
        end else if (in_key < CC) begin
          sbq[in_key].push_back({in_key, in_data});
        end else begin
          exp_pulse = 1'b1;
          if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [KW-1:0] k, input logic [DW-1:0] d);
    in_vld  = v;
    in_key  = k;
    in_data = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_rdy = '1;
    set_in(1'b0, 6'd0, 16'd0);
    repeat (2) tick();
    compared++;
    if (out_vld !== '0) begin mismatched++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    compared++;
    if (out_key !== '0 || out_data !== '0) begin
      mismatched++; $display("FAIL reset_out_kd: got %h/%h want 0/0", out_key, out_data);
    end
    compared++;
    if (drop_cnt !== 16'd0 || drop_pulse !== 1'b0) begin
      mismatched++; $display("FAIL reset_drop: got %h/%b want 0/0", drop_cnt, drop_pulse);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    out_rdy = '1;
    set_in(1'b1, 6'd2, 16'hA5A5);
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL uni_in_rdy: got %b want 1", in_rdy); end
    tick();
    set_in(1'b0, 6'd0, 16'd0);
    compared++;
    if (out_vld !== 5'b00100) begin mismatched++; $display("FAIL uni_out_vld: got %b want 00100", out_vld); end
    compared++;
    if (data_of(2) !== 16'hA5A5 || key_of(2) !== 6'd2) begin
      mismatched++; $display("FAIL uni_item: got key %h data %h want 02 a5a5", key_of(2), data_of(2));
    end
    tick();
    compared++;
    if (out_vld !== 5'b00000) begin mismatched++; $display("FAIL uni_clear: got %b want 00000", out_vld); end
  endtask

  task automatic test_backpressure();
    out_rdy = 5'b11101;
    set_in(1'b1, 6'd1, 16'h1111);
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL bp_first_rdy: got %b want 1", in_rdy); end
    tick();
    set_in(1'b1, 6'd1, 16'h2222);
    compared++;
    if (in_rdy !== 1'b0) begin mismatched++; $display("FAIL bp_second_rdy: got %b want 0", in_rdy); end
    repeat (2) tick();
    compared++;
    if (out_vld[1] !== 1'b1 || data_of(1) !== 16'h1111) begin
      mismatched++; $display("FAIL bp_hold: got vld %b data %h want 1 1111", out_vld[1], data_of(1));
    end
    out_rdy = '1;
    #1;
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL bp_release_rdy: got %b want 1", in_rdy); end
    tick();
    set_in(1'b0, 6'd0, 16'd0);
    compared++;
    if (out_vld[1] !== 1'b1 || data_of(1) !== 16'h2222) begin
      mismatched++; $display("FAIL bp_no_gap: got vld %b data %h want 1 2222", out_vld[1], data_of(1));
    end
    tick();
    compared++;
    if (out_vld !== '0) begin mismatched++; $display("FAIL bp_drain: got %b want 0", out_vld); end
  endtask

  task automatic test_independent();
    out_rdy = 5'b11110;
    set_in(1'b1, 6'd0, 16'h0A0A);
    tick();
    set_in(1'b1, 6'd4, 16'h4B4B);
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL indep_other_rdy: got %b want 1", in_rdy); end
    tick();
    set_in(1'b1, 6'd0, 16'h0C0C);
    compared++;
    if (in_rdy !== 1'b0) begin mismatched++; $display("FAIL indep_stalled_rdy: got %b want 0", in_rdy); end
    compared++;
    if (out_vld !== 5'b10001) begin mismatched++; $display("FAIL indep_vld: got %b want 10001", out_vld); end
    set_in(1'b0, 6'd0, 16'd0);
    out_rdy = '1;
    repeat (2) tick();
  endtask

  task automatic test_broadcast();
    out_rdy = 5'b10111;
    set_in(1'b1, 6'd3, 16'h0333);
    tick();
    set_in(1'b1, 6'h3F, 16'h1234);
    compared++;
    if (in_rdy !== 1'b0) begin mismatched++; $display("FAIL bc_blocked: got %b want 0", in_rdy); end
    tick();
    compared++;
    if (out_vld !== 5'b01000) begin mismatched++; $display("FAIL bc_wait_vld: got %b want 01000", out_vld); end
    out_rdy = '1;
    #1;
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL bc_ready: got %b want 1", in_rdy); end
    tick();
    set_in(1'b0, 6'd0, 16'd0);
    compared++;
    if (out_vld !== 5'b11111) begin mismatched++; $display("FAIL bc_all_vld: got %b want 11111", out_vld); end
    for (int i = 0; i < CC; i++) begin
      compared++;
      if (data_of(i) !== 16'h1234 || key_of(i) !== 6'h3F) begin
        mismatched++; $display("FAIL bc_item[%0d]: got key %h data %h want 3f 1234", i, key_of(i), data_of(i));
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_rdy = '1;
    for (int n = 0; n < 10; n++) begin
      set_in(1'b1, KW'(n % CC), DW'($urandom));
      compared++;
      if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL b2b_rdy[%0d]: got %b want 1", n, in_rdy); end
      tick();
    end
    set_in(1'b0, 6'd0, 16'd0);
    repeat (2) tick();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 6);
      out_rdy = CC'($urandom);
      set_in(($urandom_range(0, 3) != 0), (r < CC) ? KW'(r) : ((r == CC) ? 6'h3F : 6'd9), DW'($urandom));
      tick();
    end
    out_rdy = '1;
    set_in(1'b0, 6'd0, 16'd0);
    repeat (2) tick();
    compared++;
    if (out_vld !== '0) begin mismatched++; $display("FAIL rand_drained: got %b want 0", out_vld); end
  endtask

  task automatic test_illegal();
    out_rdy = '1;
    set_in(1'b1, 6'd7, 16'hDEAD);
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL ill_rdy: got %b want 1", in_rdy); end
    tick();
    set_in(1'b0, 6'd7, 16'hDEAD);
    compared++;
    if (out_vld !== '0 || drop_pulse !== 1'b1 || drop_cnt !== 16'd1) begin
      mismatched++; $display("FAIL ill_drop: got vld %b pulse %b cnt %h want 0 1 0001", out_vld, drop_pulse, drop_cnt);
    end
    tick();
    compared++;
    if (drop_pulse !== 1'b0 || drop_cnt !== 16'd1) begin
      mismatched++; $display("FAIL ill_idle: got pulse %b cnt %h want 0 0001", drop_pulse, drop_cnt);
    end
  endtask

  task automatic test_drop_saturation();
    set_in(1'b1, 6'd7, 16'h0BAD);
    repeat (65536) tick();
    compared++;
    if (drop_cnt !== 16'hFFFF || drop_pulse !== 1'b1) begin
      mismatched++; $display("FAIL sat_cnt: got cnt %h pulse %b want ffff 1", drop_cnt, drop_pulse);
    end
    set_in(1'b0, 6'd0, 16'd0);
    tick();
    compared++;
    if (drop_cnt !== 16'hFFFF || drop_pulse !== 1'b0) begin
      mismatched++; $display("FAIL sat_hold: got cnt %h pulse %b want ffff 0", drop_cnt, drop_pulse);
    end
  endtask

  task automatic test_reset_midstream();
    out_rdy = '0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, KW'(i), DW'(16'h7000 + i));
      tick();
    end
    set_in(1'b0, 6'd0, 16'd0);
    compared++;
    if (out_vld !== 5'b00111) begin mismatched++; $display("FAIL mid_full: got %b want 00111", out_vld); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_vld !== '0 || drop_cnt !== 16'd0 || out_data !== '0) begin
      mismatched++; $display("FAIL mid_async: got vld %b cnt %h want 0 0", out_vld, drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    set_in(1'b1, 6'd0, 16'hBEEF);
    compared++;
    if (in_rdy !== 1'b1) begin mismatched++; $display("FAIL mid_rdy: got %b want 1", in_rdy); end
    tick();
    set_in(1'b0, 6'd0, 16'd0);
    compared++;
    if (out_vld !== 5'b00001 || data_of(0) !== 16'hBEEF) begin
      mismatched++; $display("FAIL mid_first: got vld %b data %h want 00001 beef", out_vld, data_of(0));
    end
    out_rdy = '1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_independent();
    test_broadcast();
    test_back_to_back();
    test_illegal();
    test_random();
    test_drop_saturation();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
